// File: rtl/xs3_key_encoder.sv
// ----------------------------------------------------------------------------
// xs3_key_encoder
//
// Ten-key, one-key-at-a-time keyboard encoder producing excess-3 codes
// (key n -> n+3). It synchronises the raw key lines, debounces both press and
// release, locks out any second key while one is accepted, and keeps the last
// accepted code in a latch that drives a tri-stateable output.
//
// Ports:
//   clk   in   1   system clock, all state changes on the rising edge
//   clr   in   1   synchronous active-high reset, overrides everything
//   k_    in  10   key lines, active low, asynchronous to clk
//   oe_   in   1   active-low output enable for y
//   y     out  4   latched excess-3 code, high-impedance while oe_=1
//   da    out  1   data available: an accepted key is held (incl. release
//                  debounce window)
// ----------------------------------------------------------------------------
module xs3_key_encoder #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] k_,
  input  logic       oe_,
  output logic [3:0] y,
  output logic       da
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBP  = 2'd1,
    HELD = 2'd2,
    DBR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Two-flop synchroniser, kept in the raw active-low polarity so that the
  // cleared state ("all ones") means no key pressed.
  logic [9:0] sync1_q, sync1_d;
  logic [9:0] sync2_q, sync2_d;
  logic [9:0] ks;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       latch_q, latch_d;
  logic             da_q, da_d;

  logic [3:0] ones;
  logic [3:0] idx;
  logic       single;
  logic       none;

  assign sync1_d = k_;
  assign sync2_d = sync1_q;
  assign ks      = ~sync2_q;

  // Population count and index of the pressed key; idx is only meaningful
  // when exactly one key is pressed.
  always_comb begin
    ones = 4'd0;
    idx  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (ks[i]) begin
        ones = ones + 4'd1;
        idx  = 4'(i);
      end
    end
  end

  assign single = (ones == 4'd1);
  assign none   = (ks == 10'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    latch_d = latch_q;
    da_d    = da_q;

    case (state_q)
      IDLE: begin
        da_d = 1'b0;
        // Multiple keys from idle are never encoded: wait for a lone key.
        if (single) begin
          cand_d  = idx;
          cnt_d   = CNT_ONE;
          state_d = DBP;
        end
      end

      DBP: begin
        if (single && (idx == cand_q)) begin
          if (cnt_q == CNT_LAST) begin
            latch_d = cand_q + 4'd3;
            da_d    = 1'b1;
            cnt_d   = '0;
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      HELD: begin
        da_d = 1'b1;
        // Anything other than "no key" keeps us here: extra or replacement
        // keys are locked out and the latch is left alone.
        if (none) begin
          cnt_d   = CNT_ONE;
          state_d = DBR;
        end
      end

      DBR: begin
        if (none) begin
          if (cnt_q == CNT_LAST) begin
            da_d    = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // A release glitch returns to HELD without re-latching.
          cnt_d   = '0;
          state_d = HELD;
        end
      end

      default: begin
        cnt_d   = '0;
        da_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= '1;
      sync2_q <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'd0;
      latch_q <= 4'b0000;
      da_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      latch_q <= latch_d;
      da_q    <= da_d;
    end
  end

  assign y  = oe_ ? 4'bzzzz : latch_q;
  assign da = da_q;

endmodule

// File: tb/tb_xs3_key_encoder.sv
// ----------------------------------------------------------------------------
// tb_xs3_key_encoder
//
// Self-checking bench for xs3_key_encoder. A table of {key, code} records
// drives a press/release of every key; expected codes are queued when a key
// is pressed and popped when da rises. Hand-written sequences cover reset,
// bounce, simultaneous keys, lockout, release glitch, tri-state and reset in
// the middle of a held key.
// ----------------------------------------------------------------------------
module tb_xs3_key_encoder;

  logic       clk;
  logic       clr;
  logic [9:0] k_;
  logic       oe_;
  wire  [3:0] y;
  logic       da;

  int checks;
  int errors;

  logic [3:0] exp_q[$];
  logic [3:0] last_code;

  typedef struct {
    int         key;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[10];

  xs3_key_encoder #(
    .DEBOUNCE(4),
    .CNT_W   (4)
  ) dut (
    .clk(clk),
    .clr(clr),
    .k_ (k_),
    .oe_(oe_),
    .y  (y),
    .da (da)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Count edges until da reaches level; a timeout reports 40 edges.
  task automatic wait_da(input logic level, input int exp_edges, input string name);
    int n;
    bit found;
    n = 0;
    found = 0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (da === level) found = 1;
    end
    check(name, 8'(n), 8'(exp_edges));
  endtask

  // Queue the expected code, wait for acceptance, then compare the output.
  task automatic expect_accept(input logic [3:0] code, input string name);
    logic [3:0] e;
    exp_q.push_back(code);
    wait_da(1'b1, 6, {name, "_da_rise_edge"});
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_y"}, {4'd0, y}, {4'd0, e});
      last_code = e;
      $display("accept %-12s y=%b expected=%b", name, y, e);
    end
  endtask

  task automatic press_only(input int key);
    k_ = 10'h3FF;
    k_[key] = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_code = 4'b0000;

    vecs[0] = '{0, 4'b0011};
    vecs[1] = '{1, 4'b0100};
    vecs[2] = '{2, 4'b0101};
    vecs[3] = '{3, 4'b0110};
    vecs[4] = '{4, 4'b0111};
    vecs[5] = '{5, 4'b1000};
    vecs[6] = '{6, 4'b1001};
    vecs[7] = '{7, 4'b1010};
    vecs[8] = '{8, 4'b1011};
    vecs[9] = '{9, 4'b1100};

    // 1. Reset with key 4 held.
    clr = 1'b1;
    oe_ = 1'b0;
    press_only(4);
    tick();
    check("reset_da_e1", {7'd0, da}, 8'd0);
    check("reset_y_e1", {4'd0, y}, 8'h00);
    tick();
    check("reset_da_e2", {7'd0, da}, 8'd0);
    check("reset_y_e2", {4'd0, y}, 8'h00);
    clr = 1'b0;
    expect_accept(4'b0111, "reset_key4");
    k_ = 10'h3FF;
    wait_da(1'b0, 6, "reset_key4_release_edge");
    check("reset_key4_y_persist", {4'd0, y}, {4'd0, last_code});

    // 2. Table: clean press/hold/release of every key.
    for (int i = 0; i < 10; i++) begin
      press_only(vecs[i].key);
      expect_accept(vecs[i].code, $sformatf("key%0d", vecs[i].key));
      for (int c = 0; c < 6; c++) tick();
      check($sformatf("key%0d_hold_da", vecs[i].key), {7'd0, da}, 8'd1);
      k_ = 10'h3FF;
      wait_da(1'b0, 6, $sformatf("key%0d_release_edge", vecs[i].key));
      check($sformatf("key%0d_y_persist", vecs[i].key), {4'd0, y}, {4'd0, vecs[i].code});
    end

    // 3. Bounce on key 2: L L L H L L H, then steady low.
    begin
      bit pat[7];
      pat = '{1, 1, 1, 0, 1, 1, 0};
      for (int c = 0; c < 7; c++) begin
        if (pat[c]) press_only(2);
        else k_ = 10'h3FF;
        tick();
        check($sformatf("bounce_da_c%0d", c), {7'd0, da}, 8'd0);
      end
    end
    press_only(2);
    expect_accept(4'b0101, "bounce_key2");
    k_ = 10'h3FF;
    wait_da(1'b0, 6, "bounce_release_edge");

    // 4. Keys 3 and 5 together, then release 5.
    k_ = 10'h3FF;
    k_[3] = 1'b0;
    k_[5] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("dual_da_c%0d", c), {7'd0, da}, 8'd0);
    end
    check("dual_y_unchanged", {4'd0, y}, {4'd0, last_code});
    k_[5] = 1'b1;
    expect_accept(4'b0110, "dual_then_3");
    k_ = 10'h3FF;
    wait_da(1'b0, 6, "dual_release_edge");

    // 5. Lockout / rollover.
    press_only(1);
    expect_accept(4'b0100, "lock_key1");
    k_[9] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("lock_both_da_c%0d", c), {7'd0, da}, 8'd1);
      check($sformatf("lock_both_y_c%0d", c), {4'd0, y}, 8'h04);
    end
    k_[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("lock_9only_da_c%0d", c), {7'd0, da}, 8'd1);
      check($sformatf("lock_9only_y_c%0d", c), {4'd0, y}, 8'h04);
    end
    k_ = 10'h3FF;
    wait_da(1'b0, 6, "lock_release_edge");
    check("lock_y_persist", {4'd0, y}, 8'h04);

    // Release glitch: a one-cycle press of key 8 inside the release window.
    press_only(1);
    expect_accept(4'b0100, "glitch_key1");
    k_ = 10'h3FF;
    tick();
    tick();
    press_only(8);
    tick();
    check("glitch_da_e3", {7'd0, da}, 8'd1);
    k_ = 10'h3FF;
    for (int e = 4; e <= 8; e++) begin
      tick();
      check($sformatf("glitch_da_e%0d", e), {7'd0, da}, 8'd1);
      check($sformatf("glitch_y_e%0d", e), {4'd0, y}, 8'h04);
    end
    tick();
    check("glitch_da_fall_e9", {7'd0, da}, 8'd0);
    check("glitch_y_persist", {4'd0, y}, 8'h04);

    // 6. Tri-state and reset while held.
    press_only(9);
    expect_accept(4'b1100, "oe_key9");
    oe_ = 1'b1;
    #1;
    check("oe_off_y_released", {7'd0, (y === 4'b1100)}, 8'd0);
    check("oe_off_da", {7'd0, da}, 8'd1);
    tick();
    check("oe_off_y_released_e1", {7'd0, (y === 4'b1100)}, 8'd0);
    check("oe_off_da_e1", {7'd0, da}, 8'd1);
    oe_ = 1'b0;
    #1;
    check("oe_on_y", {4'd0, y}, 8'h0C);
    clr = 1'b1;
    tick();
    check("midclr_da", {7'd0, da}, 8'd0);
    check("midclr_y", {4'd0, y}, 8'h00);
    clr = 1'b0;
    expect_accept(4'b1100, "midclr_reaccept");
    k_ = 10'h3FF;
    wait_da(1'b0, 6, "midclr_release_edge");

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
